// File: rtl/datapath_pipe_pkg.sv
// Shared types and defaults for the register/scoreboard datapath pipe.
// Tag entries carry destination indices at a fixed maximum width.
package datapath_pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 16;
  localparam int PEND_DEF = 4;
  localparam int IDX_MAX = 8;

  function automatic int idx_w(input int nregs);
    return $clog2(nregs);
  endfunction

  typedef struct packed {
    logic [IDX_MAX-1:0] y1;
    logic [IDX_MAX-1:0] y2;
    logic [1:0]         wr;
  } tag_t;

endpackage

// File: rtl/datapath_pipe_if.sv
// Issue, operand and result bundle between the datapath and its client.
// master = issuing/executing side, slave = datapath_pipe.
interface datapath_pipe_if #(
  parameter int XLEN = 32,
  parameter int IDXW = 4
);

  logic            issue_valid;
  logic            issue_ready;
  logic [IDXW-1:0] issue_a;
  logic [IDXW-1:0] issue_b;
  logic [IDXW-1:0] issue_c;
  logic [IDXW-1:0] issue_d;
  logic [IDXW-1:0] issue_y1;
  logic [IDXW-1:0] issue_y2;
  logic [1:0]      issue_wr;
  logic            issue_const_c;
  logic [XLEN-1:0] issue_const;
  logic            issue_pc_inc;

  logic            op_valid;
  logic            op_ready;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] op_c;
  logic [XLEN-1:0] op_d;

  logic            res_valid;
  logic [XLEN-1:0] res_y1;
  logic [XLEN-1:0] res_y2;

  modport master (
    output issue_valid,
    input  issue_ready,
    output issue_a,
    output issue_b,
    output issue_c,
    output issue_d,
    output issue_y1,
    output issue_y2,
    output issue_wr,
    output issue_const_c,
    output issue_const,
    output issue_pc_inc,
    input  op_valid,
    output op_ready,
    input  op_a,
    input  op_b,
    input  op_c,
    input  op_d,
    output res_valid,
    output res_y1,
    output res_y2
  );

  modport slave (
    input  issue_valid,
    output issue_ready,
    input  issue_a,
    input  issue_b,
    input  issue_c,
    input  issue_d,
    input  issue_y1,
    input  issue_y2,
    input  issue_wr,
    input  issue_const_c,
    input  issue_const,
    input  issue_pc_inc,
    output op_valid,
    input  op_ready,
    output op_a,
    output op_b,
    output op_c,
    output op_d,
    input  res_valid,
    input  res_y1,
    input  res_y2
  );

endinterface

// File: rtl/datapath_tag_fifo.sv
// In-order FIFO of destination tags for ops awaiting results.
// count doubles as the outstanding-op counter.
module datapath_tag_fifo
  import datapath_pipe_pkg::*;
#(
  parameter int  DEPTH = PEND_DEF,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  tag_t          din,
  input  logic          pop,
  output tag_t          dout,
  output logic [CW-1:0] count
);

  tag_t          mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/datapath_pipe.sv
// Register file (R0 = PC), busy scoreboard and operand staging.
// Define DATAPATH_PIPE_BYPASS_EN to forward same-cycle results.
module datapath_pipe
  import datapath_pipe_pkg::*;
#(
  parameter int  XLEN       = XLEN_DEF,
  parameter int  NREGS      = NREGS_DEF,
  parameter int  PEND_DEPTH = PEND_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int IDXW = idx_w(NREGS),
  localparam int PW   = $clog2(PEND_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  datapath_pipe_if.slave  bus,
  output logic [XLEN-1:0] program_counter,
  output logic [PW-1:0]   pending
);

  logic [XLEN-1:0]  rf   [NREGS];
  logic [XLEN-1:0]  wdat [NREGS];
  logic [XLEN-1:0]  src  [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] clr;
  logic [NREGS-1:0] set;
  logic [NREGS-1:0] src_busy;
  tag_t             head;
  tag_t             push_tag;
  logic             res_fire;
  logic             accept;
  logic             hazard;
  logic             unused_tag;

  // A result beat with nothing outstanding is a stray and is dropped.
  assign res_fire = bus.res_valid && (pending != '0);
  assign accept   = bus.issue_valid && bus.issue_ready;

  assign unused_tag = ^{head.y1, head.y2};

  assign push_tag.y1 = IDX_MAX'(bus.issue_y1);
  assign push_tag.y2 = IDX_MAX'(bus.issue_y2);
  assign push_tag.wr = bus.issue_wr;

  datapath_tag_fifo #(
    .DEPTH (PEND_DEPTH)
  ) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (push_tag),
    .pop   (res_fire),
    .dout  (head),
    .count (pending)
  );

  // y2 is checked first so a doubled destination takes res_y2.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NREGS; i++) begin
      wdat[i] = '0;
      if (res_fire && head.wr[1] &&
          head.y2[IDXW-1:0] == IDXW'(i)) begin
        clr[i]  = 1'b1;
        wdat[i] = bus.res_y2;
      end else if (res_fire && head.wr[0] &&
                   head.y1[IDXW-1:0] == IDXW'(i)) begin
        clr[i]  = 1'b1;
        wdat[i] = bus.res_y1;
      end
    end
  end

`ifdef DATAPATH_PIPE_BYPASS_EN
  assign src_busy = busy & ~clr;
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      src[i] = clr[i] ? wdat[i] : rf[i];
    end
  end
`else
  assign src_busy = busy;
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      src[i] = rf[i];
    end
  end
`endif

  assign hazard =
      src_busy[bus.issue_a]
    | src_busy[bus.issue_b]
    | src_busy[bus.issue_d]
    | (!bus.issue_const_c && src_busy[bus.issue_c])
    | (bus.issue_wr[0] && busy[bus.issue_y1])
    | (bus.issue_wr[1] && busy[bus.issue_y2]);

  assign bus.issue_ready =
      (!bus.op_valid || bus.op_ready)
    && (pending < PW'(PEND_DEPTH))
    && !hazard;

  always_comb begin
    set = '0;
    if (accept) begin
      if (bus.issue_wr[0]) set[bus.issue_y1] = 1'b1;
      if (bus.issue_wr[1]) set[bus.issue_y2] = 1'b1;
    end
  end

  assign program_counter = rf[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf[0] <= RESET_PC;
      for (int i = 1; i < NREGS; i++) begin
        rf[i] <= '0;
      end
      busy         <= '0;
      bus.op_valid <= 1'b0;
      bus.op_a     <= '0;
      bus.op_b     <= '0;
      bus.op_c     <= '0;
      bus.op_d     <= '0;
    end else begin
      // A new set on the same index outlives the clear.
      busy <= (busy & ~clr) | set;
      for (int i = 1; i < NREGS; i++) begin
        if (clr[i]) rf[i] <= wdat[i];
      end
      if (clr[0]) begin
        rf[0] <= wdat[0];
      end else if (accept && bus.issue_pc_inc) begin
        rf[0] <= rf[0] + XLEN'(1);
      end
      if (accept) begin
        bus.op_valid <= 1'b1;
        bus.op_a     <= src[bus.issue_a];
        bus.op_b     <= src[bus.issue_b];
        bus.op_c     <= bus.issue_const_c ?
                        bus.issue_const : src[bus.issue_c];
        bus.op_d     <= src[bus.issue_d];
      end else if (bus.op_ready) begin
        bus.op_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe; follows DATAPATH_PIPE_BYPASS_EN.
// Expected values are hand-computed per step.
module tb_datapath_pipe;

  logic        clk;
  logic        rst_n;
  logic [31:0] program_counter;
  logic [2:0]  pending;
  int          n_pass;
  int          n_total;

  datapath_pipe_if #(.XLEN(32), .IDXW(4)) bus ();

  datapath_pipe #(
    .XLEN       (32),
    .NREGS      (16),
    .PEND_DEPTH (4),
    .RESET_PC   (32'h100)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .program_counter (program_counter),
    .pending         (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_issue(
    input logic [3:0]  a, b, c, d, y1, y2,
    input logic [1:0]  wr,
    input logic        cc,
    input logic [31:0] cv,
    input logic        pinc
  );
    bus.issue_valid   = 1'b1;
    bus.issue_a       = a;
    bus.issue_b       = b;
    bus.issue_c       = c;
    bus.issue_d       = d;
    bus.issue_y1      = y1;
    bus.issue_y2      = y2;
    bus.issue_wr      = wr;
    bus.issue_const_c = cc;
    bus.issue_const   = cv;
    bus.issue_pc_inc  = pinc;
  endtask

  task automatic result(input logic [31:0] v1,
                        input logic [31:0] v2);
    bus.res_valid = 1'b1;
    bus.res_y1    = v1;
    bus.res_y2    = v2;
    tick();
    bus.res_valid = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    set_issue(0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 1'b0);
    bus.issue_valid = 1'b0;
    bus.op_ready    = 1'b1;
    bus.res_valid   = 1'b0;
    bus.res_y1      = '0;
    bus.res_y2      = '0;
    tick();
    tick();
    chk("rst_pc", program_counter, 32'h100);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_opv", 32'(bus.op_valid), 0);
    #1;
    chk("rst_rdy", 32'(bus.issue_ready), 1);

    // three PC increments
    rst_n = 1'b1;
    set_issue(0, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 1'b1);
    tick();
    chk("pc1_opa", bus.op_a, 32'h100);
    chk("pc1", program_counter, 32'h101);
    tick();
    tick();
    bus.issue_valid = 1'b0;
    tick();
    chk("pc3", program_counter, 32'h103);
    chk("pc3_opv", 32'(bus.op_valid), 0);
    chk("pc3_pend", 32'(pending), 3);

    // reset aborts in-flight ops; stray results ignored
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_pend", 32'(pending), 0);
    chk("abort_pc", program_counter, 32'h100);
    result(32'h77, 32'h77);
    chk("ghost_pend", 32'(pending), 0);
    chk("ghost_pc", program_counter, 32'h100);

    // read-after-write stall on R5
    set_issue(0, 0, 0, 0, 5, 0, 2'b01, 1'b0, 32'h0, 1'b0);
    tick();
    set_issue(5, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 1'b0);
    #1;
    chk("raw_stall", 32'(bus.issue_ready), 0);
    chk("raw_pend", 32'(pending), 1);
    bus.issue_valid = 1'b0;
    result(32'hDEAD, 32'h0);
    chk("raw_pend0", 32'(pending), 0);
    set_issue(5, 0, 0, 0, 0, 0, 2'b00, 1'b0, 32'h0, 1'b0);
    #1;
    chk("raw_rdy", 32'(bus.issue_ready), 1);
    tick();
    bus.issue_valid = 1'b0;
    chk("raw_opa", bus.op_a, 32'hDEAD);
    chk("raw_opv", 32'(bus.op_valid), 1);
    result(32'h0, 32'h0);

    // y1 == y2 == R3: y2 wins, busy cleared once
    set_issue(0, 0, 0, 0, 3, 3, 2'b11, 1'b0, 32'h0, 1'b0);
    tick();
    bus.issue_valid = 1'b0;
    result(32'h1, 32'h2);
    set_issue(3, 3, 3, 3, 0, 0, 2'b00, 1'b0, 32'h0, 1'b0);
    #1;
    chk("dup_rdy", 32'(bus.issue_ready), 1);
    tick();
    bus.issue_valid = 1'b0;
    chk("dup_opa", bus.op_a, 32'h2);
    chk("dup_opc", bus.op_c, 32'h2);
    result(32'h0, 32'h0);

    // fill pending to 4, hold operands, pop one
    set_issue(0, 0, 0, 0, 0, 0, 2'b00, 1'b1, 32'h10, 1'b0);
    tick();
    bus.issue_const = 32'h11;
    tick();
    bus.issue_const = 32'h12;
    tick();
    bus.issue_const = 32'h13;
    tick();
    chk("full_pend", 32'(pending), 4);
    chk("full_rdy", 32'(bus.issue_ready), 0);
    chk("full_opc", bus.op_c, 32'h13);
    bus.op_ready    = 1'b0;
    bus.issue_const = 32'h99;
    tick();
    chk("hold_opc", bus.op_c, 32'h13);
    chk("hold_opv", 32'(bus.op_valid), 1);
    result(32'h0, 32'h0);
    chk("pop_pend", 32'(pending), 3);
    chk("pop_opc", bus.op_c, 32'h13);
    #1;
    chk("hold_rdy", 32'(bus.issue_ready), 0);
    bus.issue_valid = 1'b0;
    bus.op_ready    = 1'b1;
    tick();
    chk("drop_opv", 32'(bus.op_valid), 0);
    result(32'h0, 32'h0);
    result(32'h0, 32'h0);
    result(32'h0, 32'h0);
    chk("drain_pend", 32'(pending), 0);

    // result to R0 beats same-cycle increment
    set_issue(1, 1, 1, 1, 0, 0, 2'b01, 1'b0, 32'h0, 1'b0);
    tick();
    set_issue(1, 1, 1, 1, 0, 0, 2'b00, 1'b0, 32'h0, 1'b1);
    #1;
    chk("jmp_rdy", 32'(bus.issue_ready), 1);
    bus.res_valid = 1'b1;
    bus.res_y1    = 32'h40;
    bus.res_y2    = 32'h0;
    tick();
    bus.res_valid   = 1'b0;
    bus.issue_valid = 1'b0;
    chk("jmp_pc", program_counter, 32'h40);
    chk("jmp_pend", 32'(pending), 1);
    set_issue(1, 1, 1, 1, 0, 0, 2'b00, 1'b0, 32'h0, 1'b1);
    tick();
    bus.issue_valid = 1'b0;
    chk("inc_pc", program_counter, 32'h41);
    result(32'h0, 32'h0);
    result(32'h0, 32'h0);
    chk("jmp_drain", 32'(pending), 0);

    // same-cycle result and dependent issue on R7
    set_issue(1, 1, 1, 1, 7, 0, 2'b01, 1'b0, 32'h0, 1'b0);
    tick();
    set_issue(7, 1, 1, 1, 0, 0, 2'b00, 1'b0, 32'h0, 1'b0);
    bus.res_valid = 1'b1;
    bus.res_y1    = 32'h55;
    bus.res_y2    = 32'h0;
    #1;
`ifdef DATAPATH_PIPE_BYPASS_EN
    chk("byp_rdy", 32'(bus.issue_ready), 1);
    tick();
    bus.res_valid   = 1'b0;
    bus.issue_valid = 1'b0;
`else
    chk("byp_rdy", 32'(bus.issue_ready), 0);
    tick();
    bus.res_valid = 1'b0;
    #1;
    chk("byp_rdy2", 32'(bus.issue_ready), 1);
    tick();
    bus.issue_valid = 1'b0;
`endif
    chk("byp_opa", bus.op_a, 32'h55);
    chk("byp_pend", 32'(pending), 1);
    result(32'h0, 32'h0);
    chk("end_pend", 32'(pending), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/datapath_pipe.md
DATAPATH_PIPE -- requirements
Module: datapath_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, register and operand width.
REQ-002 SHALL have parameter NREGS, default 16, register count (power of 2, >=4); IDXW = log2(NREGS).
REQ-003 SHALL have parameter PEND_DEPTH, default 4, maximum outstanding ops awaiting results (power of 2).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-006 SHALL have issue ports: issue_valid in 1; issue_ready out 1; issue_a/b/c/d in IDXW, source indices; issue_y1/y2 in IDXW, destination indices; issue_wr in 2, write enables for y1/y2; issue_const_c in 1; issue_const in XLEN; issue_pc_inc in 1.
REQ-007 SHALL have operand ports: op_valid out 1; op_ready in 1; op_a/b/c/d out XLEN, operand values.
REQ-008 SHALL have result ports: res_valid in 1, one beat per accepted op, in issue order; res_y1/res_y2 in XLEN, result values.
REQ-009 SHALL have status ports: program_counter out XLEN, equal to R0; pending out log2(PEND_DEPTH)+1, outstanding op count.

Function
REQ-010 Register R0 SHALL be the PC; every source read of index 0 SHALL return the current PC.
REQ-011 Issue SHALL be accepted when issue_valid && issue_ready; issue_ready = (!op_valid || op_ready) && pending < PEND_DEPTH && no hazard.
REQ-012 Hazard SHALL exist when any of a, b, d, c (c only if !issue_const_c), or an enabled y1/y2 has its busy bit set.
REQ-013 On accept, operands SHALL be registered onto op_* the next cycle with op_valid=1; op_c = issue_const when issue_const_c.
REQ-014 op_* SHALL hold stable while op_valid && !op_ready; op_valid clears on op_ready unless a new accept occurs the same cycle.
REQ-015 On accept, {issue_y1, issue_y2, issue_wr} SHALL be pushed into a tag FIFO, and busy bits set for enabled destinations.
REQ-016 On res_valid, the FIFO head SHALL be popped, enabled destinations written with res_y1/res_y2, and their busy bits cleared.
REQ-017 If y1==y2 with both enabled, res_y2 SHALL be written and the busy bit cleared once.
REQ-018 Accepted issue_pc_inc SHALL increment PC by 1, modulo 2^XLEN.
REQ-019 A result write to R0 in the same cycle as a PC increment SHALL win (jump over increment).
REQ-020 Same-cycle accept and result SHALL push and pop together; pending is unchanged.
REQ-021 A same-cycle busy set by accept and clear by result on one index SHALL leave the bit set.
REQ-022 res_valid with pending==0 SHALL be ignored, with no register change.

Reset
REQ-023 While rst_n=0 at a clk edge, all registers SHALL clear to 0, except PC = RESET_PC.
REQ-024 Reset SHALL also clear busy bits, tag FIFO, pending, and op_valid; issue_ready SHALL then be 1.
REQ-025 Reset SHALL abort in-flight ops; later res_valid beats SHALL be ignored until new accepts.

Configuration
REQ-026 With DATAPATH_PIPE_BYPASS_EN defined, a source whose busy bit is being cleared by res_valid this cycle SHALL NOT cause a hazard; its operand SHALL be taken from res_y1/res_y2 (y2 precedence per REQ-017).
REQ-027 Without DATAPATH_PIPE_BYPASS_EN, that case SHALL stall one cycle and read the register file afterwards.

Structure
REQ-028 Shared package SHALL hold the tag struct {y1, y2, wr}, IDXW computation, and default parameter constants.
REQ-029 Tag FIFO SHALL be a sub-module named datapath_tag_fifo; register file, scoreboard, and PC stay in datapath_pipe.

Verification
REQ-030 Reset with RESET_PC=0x100, then accept pc_inc x3 -> program_counter=0x103, op_valid=0.
REQ-031 Issue y1=R5 wr=01, then issue a=R5 with no result -> issue_ready=0; res_y1=0xDEAD -> R5=0xDEAD; next op_a=0xDEAD.
REQ-032 Hold op_ready=0 with 4 ops accepted -> issue_ready=0 at pending=4; one res_valid -> pending=3.
REQ-033 Issue y1=y2=R3 wr=11, result 0x1/0x2 -> R3=0x2, busy clear.
REQ-034 pc_inc accept with same-cycle result to R0=0x40 -> PC=0x40.
REQ-035 Bypass build: result to R7=0x55 same cycle as issue a=R7 -> accepted, op_a=0x55; non-bypass build: one stall cycle, same op_a.
